// File: rtl/control_unit_pkg.sv
// Shared encodings for the control unit: opcodes, ALU operation codes, FSM states
// and the packed bundle of control strobes, plus the Moore output decoder.
package control_unit_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [5:0] ALU_ADD = 6'b000100;
  localparam logic [5:0] ALU_SUB = 6'b000101;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       mdr_out;
    logic       rzlo_out;
    logic       imm_out;
    logic       pc_in;
    logic       ir_in;
    logic       ry_in;
    logic       rz_in;
    logic       mar_in;
    logic       mdr_in;
    logic       read;
    logic       write;
    logic       inc_pc;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       ba_out;
    logic       r_out;
    logic       r_in;
    logic       run;
    logic [5:0] op_select;
  } ctrl_t;

  // Strobes are a pure function of the state and the latched opcode.
  function automatic ctrl_t decode_ctrl(input state_t state, input logic [4:0] opcode);
    ctrl_t c;
    logic  mem_op;
    c      = '0;
    mem_op = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
    c.run  = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1;
      end
      S_T1: begin
        c.read = 1'b1; c.mdr_in = 1'b1;
      end
      S_T2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1;
      end
      S_T3: begin
        c.grb = 1'b1; c.r_out = 1'b1; c.ry_in = 1'b1; c.ba_out = mem_op;
      end
      S_T4: begin
        c.rz_in = 1'b1;
        if (mem_op) begin
          c.imm_out = 1'b1; c.op_select = ALU_ADD;
        end else begin
          c.grc = 1'b1; c.r_out = 1'b1;
          c.op_select = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
        end
      end
      S_T5: begin
        c.rzlo_out = 1'b1;
        if ((opcode == OP_LD) || (opcode == OP_ST)) c.mar_in = 1'b1;
        else begin
          c.gra = 1'b1; c.r_in = 1'b1;
        end
      end
      S_T6: begin
        if (opcode == OP_LD) begin
          c.read = 1'b1; c.mdr_in = 1'b1;
        end else if (opcode == OP_ST) begin
          c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
        end
      end
      S_T7: begin
        if (opcode == OP_LD) begin
          c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end else if (opcode == OP_ST) c.write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit_handshake_timer.sv
// Counts consecutive cycles spent waiting on a handshake; expired flags the last
// permitted cycle so the FSM can abandon the wait on the following edge.
module handshake_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic Clock,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  // Dropping count (handshake seen or not waiting) reloads zero for the next wait.
  always_comb begin
    count_d = count ? count_q + 1'b1 : '0;
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for a small load/store CPU; outputs are registered
// decodes of the next state, so each state's strobes appear with that state.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        finished,
  input  logic        memFinished,
  output logic        PCout,
  output logic        MDRout,
  output logic        RZLOout,
  output logic        Immout,
  output logic        PCin,
  output logic        IRin,
  output logic        RYin,
  output logic        RZin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        BAout,
  output logic        Rout,
  output logic        Rin,
  output logic [5:0]  opSelect,
  output logic        start,
  output logic        run,
  output logic        fault
);

  state_t     state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       start_q, start_d;
  logic       fault_q, fault_d;
  logic       in_wait, handshake, count_en, expired;
  logic [4:0] ir_op;
  logic       unused_ir;

  assign ir_op     = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign count_en  = in_wait && !handshake;

  handshake_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .Clock   (Clock),
    .clear   (clear),
    .count   (count_en),
    .expired (expired)
  );

  // Identify which handshake (if any) the current state is blocked on.
  always_comb begin
    in_wait   = 1'b0;
    handshake = memFinished;
    case (state_q)
      S_T1:    in_wait = 1'b1;
      S_T4:    begin in_wait = 1'b1; handshake = finished; end
      S_T6:    in_wait = (opcode_q == OP_LD);
      S_T7:    in_wait = (opcode_q == OP_ST);
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    fault_d  = fault_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  if (handshake) state_d = S_T2;
      S_T2: begin
        case (ir_op)
          OP_HALT: state_d = S_HALT;
          OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB: begin
            state_d  = S_T3;
            opcode_d = ir_op;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T3: state_d = S_T4;
      S_T4: if (handshake) state_d = S_T5;
      S_T5: state_d = ((opcode_q == OP_LD) || (opcode_q == OP_ST)) ? S_T6 : S_T0;
      S_T6: if (!in_wait || handshake) state_d = S_T7;
      S_T7: if (!in_wait || handshake) state_d = S_T0;
      default: ;
    endcase
    // A wait that reaches its limit without a handshake abandons the instruction.
    if (count_en && expired) begin
      state_d = S_HALT;
      fault_d = 1'b1;
    end
    ctrl_d  = decode_ctrl(state_d, opcode_d);
    start_d = (state_d == S_T4) && (state_q != S_T4);
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_RST;
      opcode_q <= '0;
      ctrl_q   <= '0;
      start_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      ctrl_q   <= ctrl_d;
      start_q  <= start_d;
      fault_q  <= fault_d;
    end
  end

  assign PCout    = ctrl_q.pc_out;
  assign MDRout   = ctrl_q.mdr_out;
  assign RZLOout  = ctrl_q.rzlo_out;
  assign Immout   = ctrl_q.imm_out;
  assign PCin     = ctrl_q.pc_in;
  assign IRin     = ctrl_q.ir_in;
  assign RYin     = ctrl_q.ry_in;
  assign RZin     = ctrl_q.rz_in;
  assign MARin    = ctrl_q.mar_in;
  assign MDRin    = ctrl_q.mdr_in;
  assign Read     = ctrl_q.read;
  assign Write    = ctrl_q.write;
  assign IncPC    = ctrl_q.inc_pc;
  assign Gra      = ctrl_q.gra;
  assign Grb      = ctrl_q.grb;
  assign Grc      = ctrl_q.grc;
  assign BAout    = ctrl_q.ba_out;
  assign Rout     = ctrl_q.r_out;
  assign Rin      = ctrl_q.r_in;
  assign opSelect = ctrl_q.op_select;
  assign run      = ctrl_q.run;
  assign start    = start_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by cycle
// and compares every strobe against hand-written per-state expectations.
module tb_control_unit;

  logic        Clock, clear, finished, memFinished;
  logic [31:0] IR;
  logic        PCout, MDRout, RZLOout, Immout, PCin, IRin, RYin, RZin, MARin, MDRin;
  logic        Read, Write, IncPC, Gra, Grb, Grc, BAout, Rout, Rin, start, run, fault;
  logic [5:0]  opSelect;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [21:0] S_PCOUT  = 22'd1 << 21;
  localparam logic [21:0] S_MDROUT = 22'd1 << 20;
  localparam logic [21:0] S_RZLO   = 22'd1 << 19;
  localparam logic [21:0] S_IMM    = 22'd1 << 18;
  localparam logic [21:0] S_PCIN   = 22'd1 << 17;
  localparam logic [21:0] S_IRIN   = 22'd1 << 16;
  localparam logic [21:0] S_RYIN   = 22'd1 << 15;
  localparam logic [21:0] S_RZIN   = 22'd1 << 14;
  localparam logic [21:0] S_MARIN  = 22'd1 << 13;
  localparam logic [21:0] S_MDRIN  = 22'd1 << 12;
  localparam logic [21:0] S_READ   = 22'd1 << 11;
  localparam logic [21:0] S_WRITE  = 22'd1 << 10;
  localparam logic [21:0] S_INCPC  = 22'd1 << 9;
  localparam logic [21:0] S_GRA    = 22'd1 << 8;
  localparam logic [21:0] S_GRB    = 22'd1 << 7;
  localparam logic [21:0] S_GRC    = 22'd1 << 6;
  localparam logic [21:0] S_BAOUT  = 22'd1 << 5;
  localparam logic [21:0] S_ROUT   = 22'd1 << 4;
  localparam logic [21:0] S_RIN    = 22'd1 << 3;
  localparam logic [21:0] S_START  = 22'd1 << 2;
  localparam logic [21:0] S_RUN    = 22'd1 << 1;
  localparam logic [21:0] S_FAULT  = 22'd1 << 0;

  localparam logic [21:0] E_ZERO = 22'd0;
  localparam logic [21:0] E_T0   = S_RUN | S_PCOUT | S_MARIN | S_INCPC;
  localparam logic [21:0] E_T1   = S_RUN | S_READ | S_MDRIN;
  localparam logic [21:0] E_T2   = S_RUN | S_MDROUT | S_IRIN;
  localparam logic [21:0] E_T3M  = S_RUN | S_GRB | S_BAOUT | S_ROUT | S_RYIN;
  localparam logic [21:0] E_T3A  = S_RUN | S_GRB | S_ROUT | S_RYIN;
  localparam logic [21:0] E_T4M  = S_RUN | S_RZIN | S_IMM;
  localparam logic [21:0] E_T4A  = S_RUN | S_RZIN | S_GRC | S_ROUT;
  localparam logic [21:0] E_T5W  = S_RUN | S_RZLO | S_GRA | S_RIN;
  localparam logic [21:0] E_T5M  = S_RUN | S_RZLO | S_MARIN;
  localparam logic [21:0] E_T6L  = S_RUN | S_READ | S_MDRIN;
  localparam logic [21:0] E_T6S  = S_RUN | S_GRA | S_ROUT | S_MDRIN;
  localparam logic [21:0] E_T7L  = S_RUN | S_MDROUT | S_GRA | S_RIN;
  localparam logic [21:0] E_T7S  = S_RUN | S_WRITE;

  localparam logic [5:0] OPS_NONE = 6'b000000;
  localparam logic [5:0] OPS_ADD  = 6'b000100;
  localparam logic [5:0] OPS_SUB  = 6'b000101;

  control_unit #(.WAIT_LIMIT(16)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .finished(finished), .memFinished(memFinished),
    .PCout(PCout), .MDRout(MDRout), .RZLOout(RZLOout), .Immout(Immout),
    .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .IncPC(IncPC),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout), .Rout(Rout), .Rin(Rin),
    .opSelect(opSelect), .start(start), .run(run), .fault(fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive handshakes for the current cycle, then land just after the next edge.
  task automatic applyStimulus(input logic mf, input logic fin);
    memFinished = mf;
    finished    = fin;
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [21:0] expVec, input logic [5:0] expOp);
    logic [21:0] obsVec;
    obsVec = {PCout, MDRout, RZLOout, Immout, PCin, IRin, RYin, RZin, MARin, MDRin,
              Read, Write, IncPC, Gra, Grb, Grc, BAout, Rout, Rin, start, run, fault};
    assertCount++;
    assert ({obsVec, opSelect} === {expVec, expOp}) else begin
      failCount++;
      $display("[TB] FAIL %s: observed strobes=%h opSelect=%b, expected strobes=%h opSelect=%b",
               tag, obsVec, opSelect, expVec, expOp);
      $error("[TB] %s mismatch", tag);
    end
  endtask

  // T0 -> T1 (memory ready at once) -> T2 -> next edge.
  task automatic fetchPhase(input string tag, input logic [31:0] instr);
    IR = instr;
    checkOutput({tag, "_t0"}, E_T0, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    checkOutput({tag, "_t1"}, E_T1, OPS_NONE);
    applyStimulus(1'b1, 1'b0);
    checkOutput({tag, "_t2"}, E_T2, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    clear = 1'b1; IR = 32'h0; finished = 1'b0; memFinished = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("reset", E_ZERO, OPS_NONE);
    clear = 1'b0;
    applyStimulus(1'b0, 1'b0);

    // st: 8 cycles with single-cycle memory and ALU
    fetchPhase("st", 32'h1088_0005);
    checkOutput("st_t3", E_T3M, OPS_NONE);
    applyStimulus(1'b0, 1'b1);
    checkOutput("st_t4", E_T4M | S_START, OPS_ADD);
    applyStimulus(1'b0, 1'b1);
    checkOutput("st_t5", E_T5M, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    checkOutput("st_t6", E_T6S, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    checkOutput("st_t7", E_T7S, OPS_NONE);
    applyStimulus(1'b1, 1'b0);

    // ld: memory answers on the fourth cycle of T1 and of T6
    IR = 32'h0088_0005;
    checkOutput("ld_t0", E_T0, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("ld_t1_wait", E_T1, OPS_NONE);
      applyStimulus((k == 4), 1'b0);
    end
    checkOutput("ld_t2", E_T2, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    checkOutput("ld_t3", E_T3M, OPS_NONE);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ld_t4", E_T4M | S_START, OPS_ADD);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ld_t5", E_T5M, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("ld_t6_wait", E_T6L, OPS_NONE);
      applyStimulus((k == 4), 1'b0);
    end
    checkOutput("ld_t7", E_T7L, OPS_NONE);
    applyStimulus(1'b0, 1'b0);

    // add: ALU answers on the third T4 cycle, start only on the first
    fetchPhase("add", 32'h1800_0000);
    checkOutput("add_t3", E_T3A, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    checkOutput("add_t4_c1", E_T4A | S_START, OPS_ADD);
    applyStimulus(1'b0, 1'b0);
    checkOutput("add_t4_c2", E_T4A, OPS_ADD);
    applyStimulus(1'b0, 1'b0);
    checkOutput("add_t4_c3", E_T4A, OPS_ADD);
    applyStimulus(1'b0, 1'b1);
    checkOutput("add_t5", E_T5W, OPS_NONE);
    applyStimulus(1'b0, 1'b0);

    // sub: 6 cycles, ALU code SUB
    fetchPhase("sub", 32'h2000_0000);
    checkOutput("sub_t3", E_T3A, OPS_NONE);
    applyStimulus(1'b0, 1'b1);
    checkOutput("sub_t4", E_T4A | S_START, OPS_SUB);
    applyStimulus(1'b0, 1'b1);
    checkOutput("sub_t5", E_T5W, OPS_NONE);
    applyStimulus(1'b0, 1'b0);

    // ldi: 6 cycles, immediate path then register write
    fetchPhase("ldi", 32'h0888_0005);
    checkOutput("ldi_t3", E_T3M, OPS_NONE);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ldi_t4", E_T4M | S_START, OPS_ADD);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ldi_t5", E_T5W, OPS_NONE);
    applyStimulus(1'b0, 1'b0);

    // st aborted by clear while Write is held in T7
    fetchPhase("st2", 32'h1088_0005);
    checkOutput("st2_t3", E_T3M, OPS_NONE);
    applyStimulus(1'b0, 1'b1);
    checkOutput("st2_t4", E_T4M | S_START, OPS_ADD);
    applyStimulus(1'b0, 1'b1);
    checkOutput("st2_t5", E_T5M, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    checkOutput("st2_t6", E_T6S, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    checkOutput("st2_t7", E_T7S, OPS_NONE);
    #3 clear = 1'b1;
    #1 checkOutput("st2_clear_async", E_ZERO, OPS_NONE);
    #1 clear = 1'b0;
    applyStimulus(1'b0, 1'b0);

    // Unknown opcode runs as a 3-cycle nop, then halt stops without fault
    fetchPhase("op1f", 32'hF800_0000);
    IR = 32'hD800_0000;
    checkOutput("halt_t0", E_T0, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    checkOutput("halt_t1", E_T1, OPS_NONE);
    applyStimulus(1'b1, 1'b0);
    checkOutput("halt_t2", E_T2, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    checkOutput("halt_state", E_ZERO, OPS_NONE);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("halt_stays", E_ZERO, OPS_NONE);

    // Memory never answers in T1: 16 wait cycles then HALT with fault
    clear = 1'b1;
    #1 checkOutput("clear_from_halt", E_ZERO, OPS_NONE);
    clear = 1'b0;
    applyStimulus(1'b0, 1'b0);
    IR = 32'h0088_0005;
    checkOutput("to_t0", E_T0, OPS_NONE);
    applyStimulus(1'b0, 1'b0);
    checkOutput("to_t1_c1", E_T1, OPS_NONE);
    for (int k = 2; k <= 16; k++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("to_t1_wait", E_T1, OPS_NONE);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("to_fault", S_FAULT, OPS_NONE);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("to_fault_sticky", S_FAULT, OPS_NONE);
    clear = 1'b1;
    #1 checkOutput("to_clear", E_ZERO, OPS_NONE);
    clear = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("to_restart_t0", E_T0, OPS_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter WAIT_LIMIT, default 16, max cycles any handshake wait state may last before fault.
REQ-002 Clock  in  1  system clock; all state changes on rising edge.
REQ-003 clear  in  1  reset, asynchronous, active-high.
REQ-004 IR  in  32  instruction register contents; opcode = IR[31:27].
REQ-005 finished  in  1  ALU done handshake.
REQ-006 memFinished  in  1  memory read/write done handshake.
REQ-007 PCout, MDRout, RZLOout, Immout  out  1 each  bus driver selects.
REQ-008 PCin, IRin, RYin, RZin, MARin, MDRin  out  1 each  register write enables.
REQ-009 Read, Write, IncPC  out  1 each  memory strobes and PC increment.
REQ-010 Gra, Grb, Grc, BAout, Rout, Rin  out  1 each  register-file select/drive/load.
REQ-011 opSelect  out  6  ALU operation; start  out  1  ALU start pulse.
REQ-012 run  out  1  high while executing; fault  out  1  sticky handshake-timeout flag.

Function
REQ-013 Opcodes SHALL be: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, nop 11010, halt 11011; any other opcode executes as nop.
REQ-014 Outputs SHALL be Moore (decoded from state and latched opcode only); a signal not listed for a state is 0.
REQ-015 States: RST, T0..T7, HALT; each T-state lasts one cycle unless it waits on a handshake.
REQ-016 T0: PCout, MARin, IncPC; -> T1.
REQ-017 T1: Read, MDRin; stays until memFinished=1, then -> T2.
REQ-018 T2: MDRout, IRin; opcode latched from IR at the T2->T3 edge; nop -> T0; halt -> HALT; else -> T3.
REQ-019 T3: ld/ldi/st: Grb, BAout, Rout, RYin; add/sub: Grb, Rout, RYin; -> T4.
REQ-020 T4: RZin held; start high only on the first T4 cycle; ld/ldi/st: Immout, opSelect=ADD; add/sub: Grc, Rout, opSelect=ADD/SUB; stays until finished=1.
REQ-021 T5: RZLOout; ld/st: MARin, -> T6; ldi/add/sub: Gra, Rin, -> T0.
REQ-022 T6: ld: Read, MDRin, stays until memFinished=1, -> T7; st: Gra, Rout, MDRin, one cycle, -> T7.
REQ-023 T7: ld: MDRout, Gra, Rin, one cycle, -> T0; st: Write held until memFinished=1, -> T0.
REQ-024 Handshake inputs SHALL be ignored in non-waiting states; a handshake already high on wait-state entry completes that state in one cycle.
REQ-025 Each wait state SHALL count cycles; at WAIT_LIMIT cycles without handshake -> HALT with fault=1.
REQ-026 HALT: all strobes 0, run=0; remains until clear.
REQ-027 run=1 in T0..T7, 0 in RST and HALT.
REQ-028 Instruction latency (no memory/ALU stall): ldi/add/sub 6 cycles, ld/st 8 cycles, nop 3 cycles.

Reset
REQ-029 clear=1 SHALL immediately force state RST, all outputs 0, opSelect=0, fault=0, wait counter=0, aborting any in-flight instruction (Write drops combinationally).
REQ-030 First rising edge with clear=0 SHALL move RST -> T0.

Structure
REQ-031 Opcode constants, ALU codes (ADD=6'b000100, SUB=6'b000101) and state encodings SHALL live in a shared package used by datapath, control unit and benches.
REQ-032 One sub-module, handshake_timer (load/count/expire at WAIT_LIMIT), is natural; the FSM stays in control_unit.

Verification
REQ-033 st, IR=0x1088_0005 (Ra=R1=0x43, Rb=R1, C=5), memory 1-cycle -> MARin with bus 0x48 in T5, Write held in T7 until memFinished, back to T0; 8 cycles total.
REQ-034 ld, memFinished delayed 3 cycles in T1 and T6 -> T1 and T6 each last 4 cycles, MDRin held throughout, Gra+Rin in T7 only.
REQ-035 add, finished delayed 2 cycles -> start high exactly one cycle, RZin held 3 cycles, T5 asserts Gra, Rin, RZLOout.
REQ-036 memFinished never asserted in T1 -> HALT after 16 cycles, fault=1, run=0, all strobes 0 until clear.
REQ-037 clear pulsed mid-T7 of st -> Write falls in same cycle, state RST, fault=0; next edge T0 with PCout, MARin, IncPC.
REQ-038 Opcode 11111 then halt -> first executes as nop (3 cycles, no Rin/Write); second enters HALT with fault=0.
